// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the 16-bit CPU: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, enables and the memory handshake, with a bounded memory wait.
module mc_control_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic [2:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       halted,
  output logic       illegal,
  output logic       bus_error
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_J    = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          state, next_state;
  logic [TO_W-1:0] to_cnt;
  logic            waiting;
  logic            timeout_hit;
  logic            funct_ok;
  logic            decode_illegal;

  assign waiting     = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // A ready on the limit cycle completes normally; the error fires only without it.
  assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && !mem_ready && (to_cnt == TO_LAST);

  assign funct_ok = (funct == 3'b000) || (funct == 3'b001) || (funct == 3'b010) ||
                    (funct == 3'b110) || (funct == 3'b111);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      to_cnt    <= '0;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state <= next_state;
      if (waiting && !mem_ready && !timeout_hit) to_cnt <= to_cnt + TO_W'(1);
      else                                       to_cnt <= '0;
      if (decode_illegal) illegal   <= 1'b1;
      if (timeout_hit)    bus_error <= 1'b1;
    end
  end

  always_comb begin
    next_state     = state;
    decode_illegal = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_ready)        next_state = S_DECODE;
        else if (timeout_hit) next_state = S_HALT;
      end
      S_DECODE: begin
        case (opcode)
          OP_R: begin
            if (funct_ok) next_state = S_EXEC_R;
            else begin
              next_state     = S_HALT;
              decode_illegal = 1'b1;
            end
          end
          OP_ADDI, OP_LW, OP_SW: next_state = S_EXEC_I;
          OP_BEQ:                next_state = S_BRANCH;
          OP_J:                  next_state = S_JUMP;
          OP_HALT:               next_state = S_HALT;
          default: begin
            next_state     = S_HALT;
            decode_illegal = 1'b1;
          end
        endcase
      end
      S_EXEC_R: next_state = S_ALU_WB;
      S_EXEC_I: begin
        if (opcode == OP_LW)      next_state = S_MEM_RD;
        else if (opcode == OP_SW) next_state = S_MEM_WR;
        else                      next_state = S_ALU_WB;
      end
      S_MEM_RD: begin
        if (mem_ready)        next_state = S_MEM_WB;
        else if (timeout_hit) next_state = S_HALT;
      end
      S_MEM_WR: begin
        if (mem_ready)        next_state = S_FETCH;
        else if (timeout_hit) next_state = S_HALT;
      end
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b10;
      S_EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_control = funct;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_R);
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_write    = zero;
        pc_src      = 2'b01;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule
